line_buf_ctrl: RTL and testbench
================================

# line_buf_ctrl

Line-buffer controller for the direct (photometric) correspondence stage of the RGB-D visual-odometry datapath. It stores the incoming frame-1 raster stream (8-bit intensity plus 16-bit depth) in a circular window of NUM_LINES lines held in 2×NUM_LINES dual-port 1024×16 SRAM banks. For each frame-0 correspondence from the projection stage it reads frame-1 pixel and depth at the projected coordinate (idx1_x, idx1_y). It sits between the correspondence calculator and the residual/Jacobian stage, and drives the external SRAM macros directly.

## Interface
- NUM_LINES, 31, lines held in the circular buffer
- H_SIZE_BW, 10, x-index width
- V_SIZE_BW, 9, y-index width
- DEPTH_BW, 16, depth width
- CLOUD_BW, 42, transformed-z width
- SRAM_AW, 10, SRAM address width; SRAM_DW, 16, SRAM data width
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_frame_start / i_frame_end  in  1  frame-0 correspondence-stream frame pulses
- i_valid0  in  1  correspondence valid
- i_depth0  in  DEPTH_BW  frame-0 depth, passed through
- i_trans_z1  in  CLOUD_BW  transformed z, passed through
- i_idx0_x / i_idx0_y  in  H_SIZE_BW / V_SIZE_BW  frame-0 pixel index, passed through
- i_idx1_x / i_idx1_y  in  H_SIZE_BW / V_SIZE_BW  projected frame-1 index
- i_valid1, i_data1[7:0], i_depth1[DEPTH_BW-1:0]  in  frame-1 raster stream
- r_hsize / r_vsize  in  H_SIZE_BW / V_SIZE_BW  frame size (640/480)
- i_lb_sram_QA / i_lb_sram_QB  in  [2*NUM_LINES][SRAM_DW]  SRAM read data
- o_lb_sram_WENA / o_lb_sram_WENB  out  [2*NUM_LINES]  write enables, active-low
- o_lb_sram_DA / o_lb_sram_DB  out  [2*NUM_LINES][SRAM_DW]  write data
- o_lb_sram_AA / o_lb_sram_AB  out  [2*NUM_LINES][SRAM_AW]  addresses
- o_frame_start, o_frame_end, o_valid  out  1  delayed frame pulses and valid
- o_hit  out  1  frame-1 sample found in buffer
- o_depth0, o_trans_z1, o_idx0_x, o_idx0_y  out  passthrough, delayed
- o_data1 [7:0], o_depth1 [DEPTH_BW-1:0]  out  frame-1 intensity/depth at idx1

## Operation
- Bank 2k holds depth of slot k; bank 2k+1 holds intensity in bits [7:0], bits [15:8] = 0. Address = x.
- Write side (port A only): counters wr_x, wr_y, wr_slot reset to 0. Each i_valid1 writes both banks of wr_slot at wr_x; all other WENA = 1. wr_x wraps at r_hsize-1, then wr_y+1 and wr_slot+1. wr_slot wraps at NUM_LINES-1 to 0.
- When pixel (r_hsize-1, r_vsize-1) is written, set done. While done, ignore i_valid1 and treat wr_y as r_vsize. On o_frame_end, clear done and zero the counters.
- Read side (port B only): WENB always 1, DB = 0. Every bank's AB = registered idx1_x.
- hit requires all of: idx1_x < r_hsize; idx1_y < wr_y; wr_y - idx1_y <= NUM_LINES-1. This gives resident lines wr_y-30 .. wr_y-1. The line being written is never read, so there is no port collision.
- rd_slot = wr_slot - (wr_y - idx1_y); add NUM_LINES if the result is negative.
- Output mux selects QB of banks 2·rd_slot and 2·rd_slot+1.
- On a miss: o_valid = 1, o_hit = 0, o_data1 = 0, o_depth1 = 0.
- wr_x, wr_y and wr_slot are all sampled in the same cycle as i_valid0.

## Timing
- All outputs and SRAM controls are registered.
- Reset values: every output 0, except every WENA/WENB = 1.
- Write: i_valid1 sampled at edge n; AA/DA/WENA driven during cycle n+1.
- Read pipeline: sample at edge n → AB valid in cycle n+1 → QB valid in cycle n+2 (SRAM read latency is 1) → outputs valid after edge n+3. Fixed latency of 3 for o_valid, o_hit, data and all passthrough fields.
- o_frame_start and o_frame_end use the same 3-cycle delay.
- No backpressure; one correspondence per cycle is accepted.
- i_valid0 and i_valid1 may be active in the same cycle; both are served.
- Asynchronous reset mid-frame clears all counters, the done flag and the pipeline.

## Test plan
- Reset: all outputs 0 and all WEN = 1. The first i_valid1 at (0,0) drives WENA[0] = WENA[1] = 0 and AA = 0 one cycle later.
- Stream frame 1 with data1 = (x+y)&0xFF and depth1 = (640y+x)&0xFFFF; stop when wr_y = 31. Query idx1 = (5,10) → after 3 cycles o_hit = 1, o_data1 = 15, o_depth1 = 6405, and passthrough fields match the inputs.
- With wr_y = 31, query idx1_y = 0 (overwritten) and idx1_y = 31 (in progress) → o_valid = 1, o_hit = 0, data = 0. Query idx1_y = 1 → hit.
- Query idx1 = (640,10) → miss. Query idx1 = (639,30) → hit, depth1 = 19839.
- After all 480 lines: query y = 479 → hit; extra i_valid1 writes nothing. i_frame_end → o_frame_end 3 cycles later, then done clears.
- Assert rst_n low mid-stream → outputs 0 immediately. Restreaming from (0,0) reproduces the earlier results.

Source files
------------

// File: rtl/line_buf_ctrl.sv
// Line-buffer controller: keeps a circular window of frame-1 lines in SRAM banks
// and looks up frame-1 intensity/depth at each projected frame-0 correspondence.
module line_buf_ctrl #(
  parameter int unsigned NUM_LINES = 31,
  parameter int unsigned H_SIZE_BW = 10,
  parameter int unsigned V_SIZE_BW = 9,
  parameter int unsigned DEPTH_BW  = 16,
  parameter int unsigned CLOUD_BW  = 42,
  parameter int unsigned SRAM_AW   = 10,
  parameter int unsigned SRAM_DW   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_frame_start,
  input  logic                   i_frame_end,
  input  logic                   i_valid0,
  input  logic [DEPTH_BW-1:0]    i_depth0,
  input  logic [CLOUD_BW-1:0]    i_trans_z1,
  input  logic [H_SIZE_BW-1:0]   i_idx0_x,
  input  logic [V_SIZE_BW-1:0]   i_idx0_y,
  input  logic [H_SIZE_BW-1:0]   i_idx1_x,
  input  logic [V_SIZE_BW-1:0]   i_idx1_y,
  input  logic                   i_valid1,
  input  logic [7:0]             i_data1,
  input  logic [DEPTH_BW-1:0]    i_depth1,
  input  logic [H_SIZE_BW-1:0]   r_hsize,
  input  logic [V_SIZE_BW-1:0]   r_vsize,
  input  logic [SRAM_DW-1:0]     i_lb_sram_QA [2*NUM_LINES],
  input  logic [SRAM_DW-1:0]     i_lb_sram_QB [2*NUM_LINES],
  output logic [2*NUM_LINES-1:0] o_lb_sram_WENA,
  output logic [2*NUM_LINES-1:0] o_lb_sram_WENB,
  output logic [SRAM_DW-1:0]     o_lb_sram_DA [2*NUM_LINES],
  output logic [SRAM_DW-1:0]     o_lb_sram_DB [2*NUM_LINES],
  output logic [SRAM_AW-1:0]     o_lb_sram_AA [2*NUM_LINES],
  output logic [SRAM_AW-1:0]     o_lb_sram_AB [2*NUM_LINES],
  output logic                   o_frame_start,
  output logic                   o_frame_end,
  output logic                   o_valid,
  output logic                   o_hit,
  output logic [DEPTH_BW-1:0]    o_depth0,
  output logic [CLOUD_BW-1:0]    o_trans_z1,
  output logic [H_SIZE_BW-1:0]   o_idx0_x,
  output logic [V_SIZE_BW-1:0]   o_idx0_y,
  output logic [7:0]             o_data1,
  output logic [DEPTH_BW-1:0]    o_depth1
);

  localparam int unsigned NB     = 2 * NUM_LINES;
  localparam int unsigned SLOT_W = $clog2(NUM_LINES);
  localparam int unsigned SW1    = SLOT_W + 1;
  localparam int unsigned DY_W   = V_SIZE_BW + 1;
  localparam int unsigned PT_W   = 2 + DEPTH_BW + CLOUD_BW + H_SIZE_BW + V_SIZE_BW;

  logic [H_SIZE_BW-1:0] wr_x;
  logic [V_SIZE_BW-1:0] wr_y;
  logic [SLOT_W-1:0]    wr_slot;
  logic                 done;
  logic                 wr_en;

  assign wr_en = i_valid1 && !done;

  // Raster write counters; wr_y naturally lands on r_vsize once the frame is complete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_x    <= '0;
      wr_y    <= '0;
      wr_slot <= '0;
      done    <= 1'b0;
    end else if (o_frame_end) begin
      wr_x    <= '0;
      wr_y    <= '0;
      wr_slot <= '0;
      done    <= 1'b0;
    end else if (wr_en) begin
      if (wr_x == r_hsize - H_SIZE_BW'(1)) begin
        wr_x    <= '0;
        wr_y    <= wr_y + V_SIZE_BW'(1);
        wr_slot <= (wr_slot == SLOT_W'(NUM_LINES - 1)) ? '0 : wr_slot + SLOT_W'(1);
        if (wr_y == r_vsize - V_SIZE_BW'(1)) done <= 1'b1;
      end else begin
        wr_x <= wr_x + H_SIZE_BW'(1);
      end
    end
  end

  // Port A: even bank of a slot takes depth, odd bank takes zero-extended intensity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_lb_sram_WENA <= '1;
      for (int b = 0; b < NB; b++) begin
        o_lb_sram_AA[b] <= '0;
        o_lb_sram_DA[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        o_lb_sram_WENA[b] <= !(wr_en && (SLOT_W'(b >> 1) == wr_slot));
        o_lb_sram_AA[b]   <= SRAM_AW'(wr_x);
        o_lb_sram_DA[b]   <= (b % 2 == 1) ? SRAM_DW'(i_data1) : SRAM_DW'(i_depth1);
      end
    end
  end

  // Port B is read-only
  always_comb begin
    o_lb_sram_WENB = '1;
    for (int b = 0; b < NB; b++) o_lb_sram_DB[b] = '0;
  end

  logic [DY_W-1:0]   dy;
  logic              hit_c;
  logic [SW1-1:0]    slot_diff;
  logic [SLOT_W-1:0] rd_slot_c;
  logic [PT_W-1:0]   pt_in;

  // Resident lines are wr_y-NUM_LINES+1 .. wr_y-1; the line being written is excluded
  assign dy        = DY_W'(wr_y) - DY_W'(i_idx1_y);
  assign hit_c     = (i_idx1_x < r_hsize) && (i_idx1_y < wr_y) && (dy <= DY_W'(NUM_LINES - 1));
  assign slot_diff = SW1'(wr_slot) - SW1'(dy);
  assign rd_slot_c = slot_diff[SLOT_W] ? SLOT_W'(slot_diff + SW1'(NUM_LINES)) : SLOT_W'(slot_diff);
  assign pt_in     = {i_frame_start, i_frame_end, i_depth0, i_trans_z1, i_idx0_x, i_idx0_y};

  logic                s1_valid, s2_valid, s3_valid;
  logic                s1_hit, s2_hit, s3_hit;
  logic [SLOT_W-1:0]   s1_slot, s2_slot;
  logic [PT_W-1:0]     s1_pt, s2_pt, s3_pt;
  logic [7:0]          s3_data;
  logic [DEPTH_BW-1:0] s3_depth;
  logic [7:0]          q_data;
  logic [DEPTH_BW-1:0] q_depth;

  // Select the two banks of the slot whose read data is on QB this cycle
  always_comb begin
    q_data  = '0;
    q_depth = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      if (s2_slot == SLOT_W'(k)) begin
        q_depth = DEPTH_BW'(i_lb_sram_QB[2*k]);
        q_data  = i_lb_sram_QB[2*k+1][7:0];
      end
    end
  end

  logic unused_sram;
  always_comb begin
    unused_sram = 1'b0;
    for (int b = 0; b < NB; b++) unused_sram = unused_sram ^ (^i_lb_sram_QA[b]) ^ (^i_lb_sram_QB[b]);
  end

  // Read pipeline: address issue, SRAM access, QB capture, output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) o_lb_sram_AB[b] <= '0;
      s1_valid <= 1'b0; s1_hit <= 1'b0; s1_slot <= '0; s1_pt <= '0;
      s2_valid <= 1'b0; s2_hit <= 1'b0; s2_slot <= '0; s2_pt <= '0;
      s3_valid <= 1'b0; s3_hit <= 1'b0; s3_pt <= '0;
      s3_data  <= '0;
      s3_depth <= '0;
      o_valid  <= 1'b0;
      o_hit    <= 1'b0;
      o_data1  <= '0;
      o_depth1 <= '0;
      {o_frame_start, o_frame_end, o_depth0, o_trans_z1, o_idx0_x, o_idx0_y} <= '0;
    end else begin
      for (int b = 0; b < NB; b++) o_lb_sram_AB[b] <= SRAM_AW'(i_idx1_x);
      s1_valid <= i_valid0;
      s1_hit   <= i_valid0 && hit_c;
      s1_slot  <= rd_slot_c;
      s1_pt    <= pt_in;
      s2_valid <= s1_valid;
      s2_hit   <= s1_hit;
      s2_slot  <= s1_slot;
      s2_pt    <= s1_pt;
      s3_valid <= s2_valid;
      s3_hit   <= s2_hit;
      s3_pt    <= s2_pt;
      s3_data  <= s2_hit ? q_data : '0;
      s3_depth <= s2_hit ? q_depth : '0;
      o_valid  <= s3_valid;
      o_hit    <= s3_hit;
      o_data1  <= s3_data;
      o_depth1 <= s3_depth;
      {o_frame_start, o_frame_end, o_depth0, o_trans_z1, o_idx0_x, o_idx0_y} <= s3_pt;
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Directed bench for line_buf_ctrl with a behavioural model of the 62 dual-port SRAM banks.
module tb_line_buf_ctrl;

  localparam int unsigned NL = 31;
  localparam int unsigned NB = 2 * NL;
  localparam logic [NB-1:0] WEN_IDLE  = '1;
  localparam logic [NB-1:0] WEN_SLOT0 = ~62'h3;
  localparam logic [NB-1:0] WEN_SLOT1 = ~62'hC;

  logic clk = 1'b0;
  logic rst_n;
  logic i_frame_start, i_frame_end, i_valid0, i_valid1;
  logic [15:0] i_depth0, i_depth1;
  logic [41:0] i_trans_z1;
  logic [9:0]  i_idx0_x, i_idx1_x, r_hsize;
  logic [8:0]  i_idx0_y, i_idx1_y, r_vsize;
  logic [7:0]  i_data1;
  logic [15:0] qa [NB];
  logic [15:0] qb [NB];
  logic [NB-1:0] wena, wenb;
  logic [15:0] da [NB];
  logic [15:0] db [NB];
  logic [9:0]  aa [NB];
  logic [9:0]  ab [NB];
  logic        o_frame_start, o_frame_end, o_valid, o_hit;
  logic [15:0] o_depth0, o_depth1;
  logic [41:0] o_trans_z1;
  logic [9:0]  o_idx0_x;
  logic [8:0]  o_idx0_y;
  logic [7:0]  o_data1;

  int tests = 0;
  int fails = 0;

  logic          c_v_early, c_valid, c_hit;
  logic [7:0]    c_data;
  logic [15:0]   c_depth, c_depth0;
  logic [41:0]   c_tz;
  logic [9:0]    c_ix, c_aa;
  logic [8:0]    c_iy;
  logic [NB-1:0] c_wen;

  line_buf_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_valid0(i_valid0), .i_depth0(i_depth0), .i_trans_z1(i_trans_z1),
    .i_idx0_x(i_idx0_x), .i_idx0_y(i_idx0_y),
    .i_idx1_x(i_idx1_x), .i_idx1_y(i_idx1_y),
    .i_valid1(i_valid1), .i_data1(i_data1), .i_depth1(i_depth1),
    .r_hsize(r_hsize), .r_vsize(r_vsize),
    .i_lb_sram_QA(qa), .i_lb_sram_QB(qb),
    .o_lb_sram_WENA(wena), .o_lb_sram_WENB(wenb),
    .o_lb_sram_DA(da), .o_lb_sram_DB(db),
    .o_lb_sram_AA(aa), .o_lb_sram_AB(ab),
    .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
    .o_valid(o_valid), .o_hit(o_hit),
    .o_depth0(o_depth0), .o_trans_z1(o_trans_z1),
    .o_idx0_x(o_idx0_x), .o_idx0_y(o_idx0_y),
    .o_data1(o_data1), .o_depth1(o_depth1)
  );

  always #5 clk = ~clk;

  // Dual-port 1024x16 SRAM banks, one-cycle read latency on both ports
  logic [15:0] mem [NB][1024];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!wena[b]) mem[b][aa[b]] <= da[b];
      if (!wenb[b]) mem[b][ab[b]] <= db[b];
      qa[b] <= mem[b][aa[b]];
      qb[b] <= mem[b][ab[b]];
    end
  end

  function automatic logic [7:0] px_data(int x, int y);
    return 8'((x + y) & 255);
  endfunction

  function automatic logic [15:0] px_depth(int x, int y);
    return 16'((640 * y + x) & 65535);
  endfunction

  task automatic drive_pixel(int x, int y);
    @(negedge clk);
    i_valid1 = 1'b1;
    i_data1  = px_data(x, y);
    i_depth1 = px_depth(x, y);
  endtask

  task automatic stream(int p0, int p1, int w);
    for (int p = p0; p < p1; p++) drive_pixel(p % w, p / w);
    @(negedge clk);
    i_valid1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_valid0 = 1'b0;
    i_valid1 = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
  endtask

  // One correspondence; captures o_valid after edge n+2 and all outputs after edge n+3
  task automatic query(int x, int y);
    @(negedge clk);
    i_valid0   = 1'b1;
    i_idx1_x   = 10'(x);
    i_idx1_y   = 9'(y);
    i_depth0   = 16'(1000 + x);
    i_trans_z1 = 42'h200_0000_0000 | 42'(y);
    i_idx0_x   = 10'(x + 1);
    i_idx0_y   = 9'(y + 2);
    @(posedge clk);
    @(negedge clk);
    i_valid0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 c_v_early = o_valid;
    @(posedge clk);
    #1;
    c_valid  = o_valid;
    c_hit    = o_hit;
    c_data   = o_data1;
    c_depth  = o_depth1;
    c_depth0 = o_depth0;
    c_tz     = o_trans_z1;
    c_ix     = o_idx0_x;
    c_iy     = o_idx0_y;
  endtask

  task automatic test_reset();
    logic ctrl_ok;
    rst_n = 1'b0;
    i_frame_start = 1'b0; i_frame_end = 1'b0; i_valid0 = 1'b0; i_valid1 = 1'b0;
    i_depth0 = '0; i_depth1 = '0; i_trans_z1 = '0; i_data1 = '0;
    i_idx0_x = '0; i_idx0_y = '0; i_idx1_x = '0; i_idx1_y = '0;
    r_hsize = 10'd640; r_vsize = 9'd480;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({o_frame_start, o_frame_end, o_valid, o_hit, o_depth0, o_trans_z1,
         o_idx0_x, o_idx0_y, o_data1, o_depth1} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%0b hit=%0b data=%0d depth=%0d depth0=%0d idx0=(%0d,%0d), want all 0",
               o_valid, o_hit, o_data1, o_depth1, o_depth0, o_idx0_x, o_idx0_y);
    end
    ctrl_ok = (wena === WEN_IDLE) && (wenb === WEN_IDLE);
    for (int b = 0; b < NB; b++)
      if (aa[b] !== 10'd0 || ab[b] !== 10'd0 || da[b] !== 16'd0 || db[b] !== 16'd0) ctrl_ok = 1'b0;
    tests++;
    if (ctrl_ok !== 1'b1) begin
      fails++;
      $display("FAIL reset_sram_ctrl: wena=%h wenb=%h aa0=%0d da0=%0d, want wen all 1, addr/data 0",
               wena, wenb, aa[0], da[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_write();
    drive_pixel(0, 0);
    @(posedge clk);
    #1;
    tests++;
    if (wena !== WEN_SLOT0 || aa[0] !== 10'd0 || aa[1] !== 10'd0) begin
      fails++;
      $display("FAIL first_write: wena=%h aa0=%0d aa1=%0d, want wena=%h aa=0", wena, aa[0], aa[1], WEN_SLOT0);
    end
    drive_pixel(1, 0);
    @(posedge clk);
    #1;
    tests++;
    if (wena !== WEN_SLOT0 || aa[0] !== 10'd1 || da[0] !== 16'd1 || da[1] !== 16'd1) begin
      fails++;
      $display("FAIL second_write: wena=%h aa0=%0d da0=%0d da1=%0d, want wena=%h aa0=1 da0=1 da1=1",
               wena, aa[0], da[0], da[1], WEN_SLOT0);
    end
    stream(2, 31 * 640, 640);
  endtask

  task automatic test_hit();
    query(5, 10);
    tests++;
    if (c_v_early !== 1'b0) begin
      fails++;
      $display("FAIL hit_latency: o_valid after 2 edges=%0b, want 0", c_v_early);
    end
    tests++;
    if (c_valid !== 1'b1 || c_hit !== 1'b1 || c_data !== 8'd15 || c_depth !== 16'd6405) begin
      fails++;
      $display("FAIL hit_5_10: valid=%0b hit=%0b data=%0d depth=%0d, want 1 1 15 6405",
               c_valid, c_hit, c_data, c_depth);
    end
    tests++;
    if (c_depth0 !== 16'd1005 || c_tz !== 42'h200_0000_000A || c_ix !== 10'd6 || c_iy !== 9'd12) begin
      fails++;
      $display("FAIL passthrough: depth0=%0d tz=%h idx0=(%0d,%0d), want 1005 200_0000_000a (6,12)",
               c_depth0, c_tz, c_ix, c_iy);
    end
  endtask

  task automatic test_miss();
    query(5, 0);
    tests++;
    if (c_valid !== 1'b1 || c_hit !== 1'b0 || c_data !== 8'd0 || c_depth !== 16'd0) begin
      fails++;
      $display("FAIL miss_overwritten_y0: valid=%0b hit=%0b data=%0d depth=%0d, want 1 0 0 0",
               c_valid, c_hit, c_data, c_depth);
    end
    query(5, 31);
    tests++;
    if (c_valid !== 1'b1 || c_hit !== 1'b0 || c_data !== 8'd0 || c_depth !== 16'd0) begin
      fails++;
      $display("FAIL miss_in_progress_y31: valid=%0b hit=%0b data=%0d depth=%0d, want 1 0 0 0",
               c_valid, c_hit, c_data, c_depth);
    end
    query(5, 1);
    tests++;
    if (c_hit !== 1'b1 || c_data !== 8'd6 || c_depth !== 16'd645) begin
      fails++;
      $display("FAIL hit_oldest_y1: hit=%0b data=%0d depth=%0d, want 1 6 645", c_hit, c_data, c_depth);
    end
    query(640, 10);
    tests++;
    if (c_valid !== 1'b1 || c_hit !== 1'b0 || c_data !== 8'd0 || c_depth !== 16'd0) begin
      fails++;
      $display("FAIL miss_x640: valid=%0b hit=%0b data=%0d depth=%0d, want 1 0 0 0",
               c_valid, c_hit, c_data, c_depth);
    end
    query(639, 30);
    tests++;
    if (c_hit !== 1'b1 || c_data !== 8'd157 || c_depth !== 16'd19839) begin
      fails++;
      $display("FAIL hit_639_30: hit=%0b data=%0d depth=%0d, want 1 157 19839", c_hit, c_data, c_depth);
    end
  endtask

  // Three queries on consecutive cycles, with a frame-1 write alongside the first
  task automatic test_back_to_back();
    @(negedge clk);
    i_valid0 = 1'b1; i_idx1_x = 10'd5; i_idx1_y = 9'd10;
    i_valid1 = 1'b1; i_data1 = px_data(0, 31); i_depth1 = px_depth(0, 31);
    @(negedge clk);
    c_wen = wena;
    i_valid1 = 1'b0;
    i_idx1_x = 10'd5; i_idx1_y = 9'd0;
    @(negedge clk);
    i_idx1_x = 10'd639; i_idx1_y = 9'd30;
    @(negedge clk);
    i_valid0 = 1'b0;
    tests++;
    if (c_wen !== WEN_SLOT0) begin
      fails++;
      $display("FAIL b2b_concurrent_write: wena=%h, want %h", c_wen, WEN_SLOT0);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_valid !== 1'b1 || o_hit !== 1'b1 || o_data1 !== 8'd15 || o_depth1 !== 16'd6405) begin
      fails++;
      $display("FAIL b2b_first: valid=%0b hit=%0b data=%0d depth=%0d, want 1 1 15 6405",
               o_valid, o_hit, o_data1, o_depth1);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_valid !== 1'b1 || o_hit !== 1'b0 || o_data1 !== 8'd0 || o_depth1 !== 16'd0) begin
      fails++;
      $display("FAIL b2b_second: valid=%0b hit=%0b data=%0d depth=%0d, want 1 0 0 0",
               o_valid, o_hit, o_data1, o_depth1);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_valid !== 1'b1 || o_hit !== 1'b1 || o_data1 !== 8'd157 || o_depth1 !== 16'd19839) begin
      fails++;
      $display("FAIL b2b_third: valid=%0b hit=%0b data=%0d depth=%0d, want 1 1 157 19839",
               o_valid, o_hit, o_data1, o_depth1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int p = 0; p < 1000; p++) drive_pixel(p % 640, p / 640);
    @(negedge clk);
    c_wen = wena;
    c_aa  = aa[2];
    rst_n = 1'b0;
    #1;
    tests++;
    if (c_wen !== WEN_SLOT1 || c_aa !== 10'd359) begin
      fails++;
      $display("FAIL mid_stream_before_reset: wena=%h aa2=%0d, want %h 359", c_wen, c_aa, WEN_SLOT1);
    end
    tests++;
    if (wena !== WEN_IDLE || aa[2] !== 10'd0 || o_idx0_x !== 10'd0 || o_depth0 !== 16'd0) begin
      fails++;
      $display("FAIL async_reset: wena=%h aa2=%0d idx0_x=%0d depth0=%0d, want all-1 0 0 0",
               wena, aa[2], o_idx0_x, o_depth0);
    end
    i_valid1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    stream(0, 11 * 640, 640);
    query(5, 10);
    tests++;
    if (c_hit !== 1'b1 || c_data !== 8'd15 || c_depth !== 16'd6405) begin
      fails++;
      $display("FAIL restream_hit_5_10: hit=%0b data=%0d depth=%0d, want 1 15 6405", c_hit, c_data, c_depth);
    end
    query(5, 11);
    tests++;
    if (c_valid !== 1'b1 || c_hit !== 1'b0 || c_data !== 8'd0) begin
      fails++;
      $display("FAIL restream_miss_y11: valid=%0b hit=%0b data=%0d, want 1 0 0", c_valid, c_hit, c_data);
    end
  endtask

  // Small 16x48 frame so the whole frame fits in the cycle budget
  task automatic test_frame_done();
    do_reset();
    r_hsize = 10'd16;
    r_vsize = 9'd48;
    stream(0, 16 * 48, 16);
    query(3, 47);
    tests++;
    if (c_hit !== 1'b1 || c_data !== 8'd50 || c_depth !== 16'd30083) begin
      fails++;
      $display("FAIL done_hit_last_line: hit=%0b data=%0d depth=%0d, want 1 50 30083", c_hit, c_data, c_depth);
    end
    query(3, 18);
    tests++;
    if (c_hit !== 1'b1 || c_data !== 8'd21 || c_depth !== 16'd11523) begin
      fails++;
      $display("FAIL done_hit_oldest: hit=%0b data=%0d depth=%0d, want 1 21 11523", c_hit, c_data, c_depth);
    end
    query(3, 17);
    tests++;
    if (c_valid !== 1'b1 || c_hit !== 1'b0) begin
      fails++;
      $display("FAIL done_miss_y17: valid=%0b hit=%0b, want 1 0", c_valid, c_hit);
    end
    @(negedge clk);
    i_valid1 = 1'b1; i_data1 = 8'hAA; i_depth1 = 16'hBEEF;
    @(posedge clk);
    #1;
    tests++;
    if (wena !== WEN_IDLE) begin
      fails++;
      $display("FAIL done_ignores_write: wena=%h, want %h", wena, WEN_IDLE);
    end
    @(negedge clk);
    i_valid1 = 1'b0;
    query(3, 47);
    tests++;
    if (c_hit !== 1'b1 || c_data !== 8'd50 || c_depth !== 16'd30083) begin
      fails++;
      $display("FAIL done_hit_after_extra: hit=%0b data=%0d depth=%0d, want 1 50 30083", c_hit, c_data, c_depth);
    end
    @(negedge clk);
    i_frame_start = 1'b1; i_frame_end = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_frame_start = 1'b0; i_frame_end = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (o_frame_start !== 1'b0 || o_frame_end !== 1'b0) begin
      fails++;
      $display("FAIL frame_pulse_early: start=%0b end=%0b, want 0 0", o_frame_start, o_frame_end);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_frame_start !== 1'b1 || o_frame_end !== 1'b1) begin
      fails++;
      $display("FAIL frame_pulse_delay3: start=%0b end=%0b, want 1 1", o_frame_start, o_frame_end);
    end
    @(posedge clk);
    #1;
    tests++;
    if (o_frame_start !== 1'b0 || o_frame_end !== 1'b0) begin
      fails++;
      $display("FAIL frame_pulse_width: start=%0b end=%0b, want 0 0", o_frame_start, o_frame_end);
    end
    drive_pixel(0, 0);
    @(posedge clk);
    #1;
    tests++;
    if (wena !== WEN_SLOT0 || aa[0] !== 10'd0) begin
      fails++;
      $display("FAIL write_after_frame_end: wena=%h aa0=%0d, want %h 0", wena, aa[0], WEN_SLOT0);
    end
    @(negedge clk);
    i_valid1 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_write();
    test_hit();
    test_miss();
    test_back_to_back();
    test_reset_mid();
    test_frame_done();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
